// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe
// Branch-metric computer for a rate 1/N convolutional decoder. Each accepted
// beat carries N soft symbols; the block produces one metric per code-word
// hypothesis (2^N of them) after two register stages with full
// valid/ready backpressure.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   rx_sym / erase_in / sync are valid this cycle
//   in_ready   block accepts a beat this cycle
//   rx_sym     N soft symbols, symbol j at [j*SW +: SW] (0 = strong 0, MAXV = strong 1)
//   erase_in   per-code-bit external erasure flags
//   sync       accompanying beat is puncture phase 0
//   hard_mode  1 = hard-decision metrics (sampled with each beat)
//   out_valid  bm is valid
//   out_ready  downstream consumes bm this cycle
//   bm         metric for hypothesis h at [h*MW +: MW]
module bmc_soft_pipe #(
    parameter int N        = 2,
    parameter int SW       = 3,
    parameter int PUNC_LEN = 1,
    parameter logic [N*PUNC_LEN-1:0] PUNC_PATTERN = '1,
    localparam int MAXV    = (1 << SW) - 1,
    localparam int MW      = $clog2(N * MAXV + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*SW-1:0]       rx_sym,
    input  logic [N-1:0]          erase_in,
    input  logic                  sync,
    input  logic                  hard_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(2**N)*MW-1:0]  bm
);

    localparam int NH = 1 << N;
    localparam int PW = (PUNC_LEN > 1) ? $clog2(PUNC_LEN) : 1;

    logic [PW-1:0]      r_phase;
    logic               r_s1_valid;
    logic [N*SW-1:0]    r_s1_sym;
    logic [N-1:0]       r_s1_erase;
    logic               r_s1_hard;
    logic               r_s2_valid;
    logic [NH*MW-1:0]   r_bm;

    logic               w_s2_load;
    logic               w_in_xfer;
    logic [PW-1:0]      w_phase;
    logic [PW-1:0]      w_phase_next;
    logic [N-1:0]       w_erase;
    logic [MW-1:0]      w_r [N];
    logic [MW-1:0]      w_sum;
    logic [NH*MW-1:0]   w_bm;

    // S2 takes a new value whenever it is empty or being drained; S1 can
    // accept whenever it is empty or moving into S2 this cycle.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_xfer = in_valid && in_ready;
    assign out_valid = r_s2_valid;
    assign bm        = r_bm;

    // A sync beat is forced to phase 0; the following beat continues from 1.
    assign w_phase      = sync ? '0 : r_phase;
    assign w_phase_next = (int'(w_phase) == PUNC_LEN - 1) ? '0 : w_phase + PW'(1);

    // Punctured positions are treated exactly like externally erased bits.
    always_comb begin
        w_erase = erase_in;
        for (int j = 0; j < N; j++) begin
            if (!PUNC_PATTERN[int'(w_phase) * N + j]) begin
                w_erase[j] = 1'b1;
            end
        end
    end

    // Per-hypothesis metric: distance of each kept symbol from the ideal
    // level for that hypothesis bit. Erased bits contribute nothing, so an
    // all-erased beat yields all-zero metrics.
    always_comb begin
        w_bm  = '0;
        w_sum = '0;
        for (int j = 0; j < N; j++) begin
            w_r[j] = '0;
            if (r_s1_hard) begin
                w_r[j] = r_s1_sym[j*SW + SW - 1] ? MW'(MAXV) : '0;
            end else begin
                w_r[j] = MW'(r_s1_sym[j*SW +: SW]);
            end
        end
        for (int h = 0; h < NH; h++) begin
            w_sum = '0;
            for (int j = 0; j < N; j++) begin
                if (!r_s1_erase[j]) begin
                    if (((h >> j) & 1) != 0) begin
                        w_sum = w_sum + (MW'(MAXV) - w_r[j]);
                    end else begin
                        w_sum = w_sum + w_r[j];
                    end
                end
            end
            w_bm[h*MW +: MW] = w_sum;
        end
    end

    // Puncture phase advances only on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (w_in_xfer) begin
            r_phase <= w_phase_next;
        end
    end

    // Stage 1: raw symbols, effective erase mask and the hard/soft choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sym   <= '0;
            r_s1_erase <= '0;
            r_s1_hard  <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sym   <= rx_sym;
                r_s1_erase <= w_erase;
                r_s1_hard  <= hard_mode;
            end
        end
    end

    // Stage 2: registered metrics; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_bm       <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_bm <= w_bm;
            end
        end
    end

endmodule

// File: doc/bmc_soft_pipe.md
BMC_SOFT_PIPE -- requirements
Module: bmc_soft_pipe

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning code outputs per trellis branch (rate 1/N); legal range 2..4.
REQ-002 The block SHALL have parameter SW, default 3, meaning soft-symbol width in bits; legal range 1..8; MAXV = 2^SW-1.
REQ-003 The block SHALL have parameter PUNC_LEN, default 1, meaning puncture period in beats; legal range 1..8.
REQ-004 The block SHALL have parameter PUNC_PATTERN, width N*PUNC_LEN, default all ones; bit k*N+j=1 keeps code bit j in beat phase k, 0 punctures it.
REQ-005 The block SHALL have derived localparam MW = clog2(N*MAXV+1), meaning branch-metric width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: rx_sym/erase_in/sync are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The block SHALL have port rx_sym, input, N*SW bits: soft symbol j at [j*SW +: SW]; 0 = strongest 0, MAXV = strongest 1.
REQ-011 The block SHALL have port erase_in, input, N bits: external erasure flag per code bit.
REQ-012 The block SHALL have port sync, input, 1 bit: the accompanying beat is puncture phase 0.
REQ-013 The block SHALL have port hard_mode, input, 1 bit, quasi-static: 1 = hard-decision metrics.
REQ-014 The block SHALL have port out_valid, output, 1 bit: bm is valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream consumes bm this cycle.
REQ-016 The block SHALL have port bm, output, (2^N)*MW bits: metric for hypothesis h at [h*MW +: MW].

Function
REQ-017 A beat SHALL transfer on in_valid && in_ready; an output SHALL transfer on out_valid && out_ready.
REQ-018 The datapath SHALL be two register stages: S1 holds rx_sym plus the effective erase mask; S2 holds the computed bm.
REQ-019 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays 1; throughput SHALL be 1 beat/cycle.
REQ-020 S2 SHALL load when !s2_valid || out_ready; S1 SHALL advance into S2 under the same condition; in_ready SHALL equal !s1_valid || (!s2_valid || out_ready).
REQ-021 While out_valid && !out_ready, bm and out_valid SHALL hold stable; no accepted beat SHALL be lost or duplicated.
REQ-022 The puncture phase counter SHALL be 0..PUNC_LEN-1 and advance only on input transfer, wrapping PUNC_LEN-1 -> 0.
REQ-023 On an input transfer with sync=1, that beat SHALL use phase 0 and the next beat phase 1 (mod PUNC_LEN); sync without transfer SHALL be ignored.
REQ-024 Effective erase for bit j SHALL be erase_in[j] OR (PUNC_PATTERN[phase*N+j]==0), captured into S1.
REQ-025 In hard_mode, each symbol SHALL first map to MAXV if its MSB is 1, else 0.
REQ-026 bm[h] SHALL be the sum over non-erased j of (h bit j ? MAXV-r_j : r_j), unsigned, computed at full MW width with no saturation.
REQ-027 If all N bits are erased, all 2^N metrics SHALL be 0.
REQ-028 hard_mode SHALL be sampled into S1 with the beat, so a change affects only beats accepted afterwards.

Reset
REQ-029 With rst_n low, out_valid, s1_valid, bm, S1 contents and the phase counter SHALL clear to 0 asynchronously; in_ready SHALL read 1.
REQ-030 Reset SHALL discard all in-flight beats; the first beat after release SHALL use phase 0.

Verification
REQ-031 N=2, SW=3, soft mode, r0=2, r1=6, out_ready=1 -> two cycles later bm = {h0:8, h1:11, h2:3, h3:6}.
REQ-032 Same input with hard_mode=1 -> bm = {7, 14, 0, 7}.
REQ-033 PUNC_LEN=2, PUNC_PATTERN=4'b0111, sync on beat 0, two beats r0=2, r1=6 -> beat 0 bm = {8, 11, 3, 6}; beat 1 bm = {2, 5, 2, 5}.
REQ-034 out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 beats accepted, then in_ready=0 and bm stable; on out_ready=1, outputs emerge in order with none lost.
REQ-035 erase_in=2'b11 -> all metrics 0; erase_in=2'b01 with r1=6 -> bm = {6, 6, 1, 1}.
REQ-036 rst_n pulsed low with both stages full -> out_valid=0 and bm=0 immediately; after release the next beat is phase 0 and arrives 2 cycles later.
